// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions: ALUOp codes and the issue FSM state encoding.
// Imported by the issue controller and by the ALU itself.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_ADD = 3'b101,
    ALU_SUB = 3'b110,
    ALU_MOD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_sat_counter16.sv
// sat_counter16: 16-bit up-counter with synchronous clear, count enable and
// saturation at 16'hFFFF.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset (count -> 0)
//   clear  - synchronous clear (count -> 0), wins over enable
//   enable - increment by one, holding at 16'hFFFF
//   count  - registered count value
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issues one request at a time to a multi-cycle ALU, waits for its
// result-valid flag (with divide-by-zero and timeout aborts) and holds the
// response until the consumer takes it.
// Ports:
//   clk, reset                  - clock; synchronous active-low reset
//   req_valid/req_ready         - request handshake
//   req_op, req_a, req_b, req_tag - request ALUOp, operands, caller tag
//   alu_op, alu_a, alu_b        - registered drive to the ALU
//   alu_result, alu_c, alu_we   - ALU result, carry-out, result-valid
//   rsp_valid/rsp_ready         - response handshake
//   rsp_result, rsp_carry, rsp_err, rsp_tag, rsp_cycles - response payload
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request, ALU inputs parked at zero
// ST_EXEC | operands held on the ALU, counting cycles until done/abort
// ST_RESP | response valid and frozen until rsp_ready, ALUOp parked at AND
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_c,
  input  logic        alu_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [3:0]  rsp_tag,
  output logic [15:0] rsp_cycles
);

  issue_state_e state;
  logic [3:0]   tag_q;
  logic [15:0]  cnt_q;
  logic [15:0]  exec_cycles;
  logic         accept;
  logic         mod_by_zero;

  assign accept = (state == ST_IDLE) && req_valid;

  // The counter is cleared on accept and advances at the end of each EXEC
  // cycle, so the number of the current EXEC cycle is one ahead of it.
  assign exec_cycles = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // alu_op/alu_b are the latched operands while in EXEC.
  assign mod_by_zero = (alu_op == ALU_MOD) && (alu_b == 32'd0);

  sat_counter16 u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == ST_EXEC),
    .count  (cnt_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      alu_op     <= ALU_AND;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      tag_q      <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= 4'd0;
      rsp_cycles <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_op    <= req_op;
            alu_a     <= req_a;
            alu_b     <= req_b;
            tag_q     <= req_tag;
            req_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (mod_by_zero || alu_we || (exec_cycles == MAX_CYCLES)) begin
            // Divide-by-zero is known from the latched operands and is
            // reported before the ALU's flag is even looked at; a real
            // result on the limit cycle still beats the timeout.
            if (!mod_by_zero && alu_we) begin
              rsp_result <= alu_result;
              rsp_carry  <= alu_c;
              rsp_err    <= 1'b0;
              rsp_cycles <= exec_cycles;
            end else begin
              rsp_result <= 32'd0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_cycles <= mod_by_zero ? exec_cycles : MAX_CYCLES;
            end
            rsp_tag   <= tag_q;
            rsp_valid <= 1'b1;
            // Dropping ALUOp to AND releases MOD so the mod unit re-arms.
            alu_op    <= ALU_AND;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_op    <= ALU_AND;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU: single-cycle
// ops report result-valid immediately, MOD reports it on its 4th cycle, and
// we_stuck0 forces result-valid low to provoke the timeout (MAX_CYCLES=8).
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [3:0]  req_tag = 4'd0;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_c;
  logic        alu_we;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [15:0] rsp_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  logic       we_stuck0 = 1'b0;
  logic [3:0] mod_cnt;

  always #5 clk = ~clk;

  alu_issue #(.MAX_CYCLES(16'd8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_we     (alu_we),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .rsp_cycles (rsp_cycles)
  );

  // ALU model
  always_ff @(posedge clk) begin
    if (!reset || alu_op != 3'b111) mod_cnt <= 4'd0;
    else                            mod_cnt <= mod_cnt + 4'd1;
  end

  always_comb begin
    logic [32:0] sum;
    sum        = 33'd0;
    alu_result = 32'd0;
    alu_c      = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = ~(alu_a | alu_b);
      3'b100: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b101: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_c = sum[32];
      end
      3'b110: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum[31:0];
        alu_c = sum[32];
      end
      default: alu_result = (alu_b != 32'd0) ? (alu_a % alu_b) : 32'd0;
    endcase
    if (we_stuck0)            alu_we = 1'b0;
    else if (alu_op == 3'b111) alu_we = (mod_cnt == 4'd3);
    else                      alu_we = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request for one edge; leaves the bench at the negedge after
  // the accept edge (first EXEC cycle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  // edges counts rising edges from (and including) the accept edge.
  task automatic wait_rsp(input string tag, input logic [2:0] exp_op, output int edges);
    int bad;
    bad   = 0;
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      if (alu_op !== exp_op || req_ready !== 1'b0) bad++;
      tick();
      edges++;
    end
    check_eq({tag, "_exec_hold"}, bad, 0);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_resp_aluop"}, {29'd0, alu_op}, 32'd0);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int edges;
    int unstable;
    int spurious;
    logic [31:0] snap_result;
    logic [15:0] snap_cycles;
    logic [3:0]  snap_tag;

    // Reset
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_rsp_flags", {29'd0, rsp_carry, rsp_err, 1'b0}, 32'd0);
    check_eq("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    check_eq("rst_rsp_cycles", {16'd0, rsp_cycles}, 32'd0);
    check_eq("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check_eq("rst_alu_ab", alu_a | alu_b, 32'd0);

    // ADD 5+7, single cycle
    issue(3'b101, 32'd5, 32'd7, 4'h3);
    check_eq("add_alu_a", alu_a, 32'd5);
    check_eq("add_alu_b", alu_b, 32'd7);
    wait_rsp("add", 3'b101, edges);
    check_eq("add_latency", edges, 2);
    check_eq("add_result", rsp_result, 32'd12);
    check_eq("add_carry", {31'd0, rsp_carry}, 32'd0);
    check_eq("add_err", {31'd0, rsp_err}, 32'd0);
    check_eq("add_cycles", {16'd0, rsp_cycles}, 32'd1);
    check_eq("add_tag", {28'd0, rsp_tag}, 32'h3);
    take_rsp("add");

    // SUB 3-5
    issue(3'b110, 32'd3, 32'd5, 4'hA);
    wait_rsp("sub", 3'b110, edges);
    check_eq("sub_result", rsp_result, 32'hFFFF_FFFE);
    check_eq("sub_carry", {31'd0, rsp_carry}, 32'd0);
    check_eq("sub_tag", {28'd0, rsp_tag}, 32'hA);
    take_rsp("sub");

    // Modulo 17%5, ALU done on 4th EXEC cycle
    issue(3'b111, 32'd17, 32'd5, 4'h5);
    wait_rsp("mod", 3'b111, edges);
    check_eq("mod_latency", edges, 5);
    check_eq("mod_result", rsp_result, 32'd2);
    check_eq("mod_cycles", {16'd0, rsp_cycles}, 32'd4);
    check_eq("mod_err", {31'd0, rsp_err}, 32'd0);
    take_rsp("mod");

    // Modulo by zero
    issue(3'b111, 32'd17, 32'd0, 4'h6);
    wait_rsp("mod0", 3'b111, edges);
    check_eq("mod0_latency", edges, 2);
    check_eq("mod0_err", {31'd0, rsp_err}, 32'd1);
    check_eq("mod0_result", rsp_result, 32'd0);
    check_eq("mod0_cycles", {16'd0, rsp_cycles}, 32'd1);
    check_eq("mod0_tag", {28'd0, rsp_tag}, 32'h6);
    take_rsp("mod0");

    // Timeout at MAX_CYCLES=8
    we_stuck0 = 1'b1;
    issue(3'b101, 32'd1, 32'd2, 4'h9);
    wait_rsp("tmo", 3'b101, edges);
    we_stuck0 = 1'b0;
    check_eq("tmo_latency", edges, 9);
    check_eq("tmo_err", {31'd0, rsp_err}, 32'd1);
    check_eq("tmo_result", rsp_result, 32'd0);
    check_eq("tmo_cycles", {16'd0, rsp_cycles}, 32'd8);
    take_rsp("tmo");

    // Carry out, then 10 cycles of backpressure with a competing request
    issue(3'b101, 32'hFFFF_FFFF, 32'd1, 4'h7);
    wait_rsp("bp", 3'b101, edges);
    check_eq("bp_result", rsp_result, 32'd0);
    check_eq("bp_carry", {31'd0, rsp_carry}, 32'd1);
    snap_result = rsp_result;
    snap_cycles = rsp_cycles;
    snap_tag    = rsp_tag;
    unstable    = 0;
    req_valid   = 1'b1;
    req_op      = 3'b001;
    req_a       = 32'h55;
    req_b       = 32'hAA;
    req_tag     = 4'hE;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== snap_result ||
          rsp_cycles !== snap_cycles || rsp_tag !== snap_tag || rsp_carry !== 1'b1)
        unstable++;
    end
    check_eq("bp_stable", unstable, 0);
    req_valid = 1'b0;
    take_rsp("bp");
    check_eq("idle_hold_result", rsp_result, 32'd0);
    check_eq("idle_hold_tag", {28'd0, rsp_tag}, 32'h7);
    tick();
    check_eq("idle_no_accept", {31'd0, req_ready}, 32'd1);

    // Reset in the 2nd EXEC cycle of a MOD
    issue(3'b111, 32'd17, 32'd5, 4'hB);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mrst_alu_op", {29'd0, alu_op}, 32'd0);
    check_eq("mrst_alu_ab", alu_a | alu_b, 32'd0);
    check_eq("mrst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
    check_eq("mrst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) spurious++;
      tick();
    end
    check_eq("mrst_no_rsp", spurious, 0);

    // Recovery after reset
    issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 4'h1);
    wait_rsp("and", 3'b000, edges);
    check_eq("and_result", rsp_result, 32'h0000_F000);
    check_eq("and_tag", {28'd0, rsp_tag}, 32'h1);
    take_rsp("and");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter MAX_CYCLES, default 16'hFFFF, SHALL set the EXEC cycle limit before timeout abort.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 req_valid  input  1  SHALL mark an operation request.
REQ-005 req_ready  output  1  SHALL mark that a request is accepted this cycle.
REQ-006 req_op  input  3  SHALL carry the ALUOp code: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD.
REQ-007 req_a, req_b  input  32 each  SHALL carry the operands.
REQ-008 req_tag  input  4  SHALL carry a caller ID returned unchanged with the response.
REQ-009 alu_op  output  3  SHALL drive the ALU ALUOp input.
REQ-010 alu_a, alu_b  output  32 each  SHALL drive the ALU A and B inputs.
REQ-011 alu_result  input  32  SHALL receive the ALU Result.
REQ-012 alu_c  input  1  SHALL receive the ALU carry-out C.
REQ-013 alu_we  input  1  SHALL receive the ALU We (result-valid) flag.
REQ-014 rsp_valid  output  1  SHALL mark a valid response.
REQ-015 rsp_ready  input  1  SHALL mark that the consumer accepts the response.
REQ-016 rsp_result  output  32  SHALL carry the response result.
REQ-017 rsp_carry  output  1  SHALL carry the response carry.
REQ-018 rsp_err  output  1  SHALL flag a response error.
REQ-019 rsp_tag  output  4  SHALL return the request tag.
REQ-020 rsp_cycles  output  16  SHALL report the number of EXEC cycles spent.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-022 In IDLE: req_ready=1, alu_op=000, alu_a=alu_b=0.
REQ-023 In IDLE with req_valid=1: latch op/a/b/tag, clear the counter, go to EXEC.
REQ-024 In EXEC: req_ready=0 and alu_op/alu_a/alu_b SHALL hold the latched values stable every cycle.
REQ-025 In EXEC the cycle counter SHALL count 1 on the first cycle and increment each further cycle.
REQ-026 EXEC with alu_we=1: capture alu_result into rsp_result, alu_c into rsp_carry, counter into rsp_cycles, set rsp_err=0, go to RESP.
REQ-027 A single-cycle op (alu_we already 1) SHALL complete in one EXEC cycle: rsp_valid rises 2 cycles after the accept edge.
REQ-028 Op 111 with latched b=0: in the first EXEC cycle go to RESP with rsp_err=1, rsp_result=0, rsp_carry=0, rsp_cycles=1, ignoring alu_we.
REQ-029 EXEC timeout: if the counter equals MAX_CYCLES and alu_we=0, go to RESP with rsp_err=1, rsp_result=0, rsp_cycles=MAX_CYCLES.
REQ-030 If alu_we=1 in the same cycle the limit is reached, capture SHALL take priority over timeout.
REQ-031 In RESP: rsp_valid=1 with all rsp_* outputs stable until rsp_ready=1.
REQ-032 In RESP: alu_op=000 (this de-asserts MOD so the ALU mod unit re-arms).
REQ-033 RESP with rsp_ready=1: go to IDLE; the next acceptance is no earlier than the following cycle (minimum 3 cycles per operation).
REQ-034 req_valid SHALL be ignored outside IDLE; no request is queued or dropped silently (req_ready=0 there).
REQ-035 rsp_* outputs outside RESP SHALL hold their last values; rsp_valid=0.

Reset
REQ-036 On Clk edge with Reset=0: state IDLE; req_ready=1 when Reset=1 again; rsp_valid=0.
REQ-037 Reset outputs SHALL be: rsp_result=0, rsp_carry=0, rsp_err=0, rsp_tag=0, rsp_cycles=0, alu_op=000, alu_a=alu_b=0, counter=0.
REQ-038 Reset mid-EXEC or mid-RESP SHALL abandon the operation with no response produced.

Structure
REQ-039 ALUOp code constants and FSM state encodings SHALL reside in the shared ALU definitions package, used by this block and the ALU.
REQ-040 One sub-module, sat_counter16 (clear, enable, 16-bit count, saturating at FFFF), SHALL implement the cycle counter.

Verification
REQ-041 ADD a=5, b=7, ALU model combinational -> rsp_result=12, rsp_carry=0, rsp_err=0, rsp_cycles=1, rsp_valid 2 cycles after accept.
REQ-042 SUB a=3, b=5 -> rsp_result=FFFFFFFE, rsp_carry=0; tag 4'hA returned as 4'hA.
REQ-043 MOD a=17, b=5, ALU model asserting alu_we after 4 cycles -> rsp_result=2, rsp_cycles=4, alu_op=111 stable throughout EXEC, then 000 in RESP.
REQ-044 MOD b=0 -> rsp_err=1, rsp_result=0, rsp_cycles=1; MAX_CYCLES=8 with alu_we stuck 0 -> rsp_err=1, rsp_cycles=8.
REQ-045 rsp_ready held 0 for 10 cycles -> rsp_* stable and req_ready=0 throughout; the response is accepted on the cycle rsp_ready=1.
REQ-046 Reset=0 asserted in the 2nd EXEC cycle of a MOD -> the next cycle shows IDLE reset values, and no rsp_valid pulse occurs.
